// File: rtl/hevc_dct_coeff_gen.sv
// hevc_dct_coeff_gen
// Streams one row (or one column in transpose mode) of the 4/8/16/32-point
// HEVC integer DCT matrix as LANES-wide beats under valid/ready handshakes.
// Every coefficient comes from the 32-point matrix by folding the cosine
// phase into the first quadrant and looking it up in a 31-entry table.

module hevc_dct_coeff_gen #(
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_size,
   input  logic [4:0]           req_idx,
   input  logic                 req_transpose,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_coeff,
   output logic [4:0]           out_beat,
   output logic                 out_last,
   output logic                 req_err
);

   localparam int COEF_W  = 8;
   localparam int LANE_LG = (LANES == 4) ? 2 : ((LANES == 2) ? 1 : 0);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   // First-quadrant magnitudes: T[m] for m = 1..31; index 0 is the DC value.
   function automatic logic signed [COEF_W-1:0] f_tval(input logic [4:0] a);
      logic signed [COEF_W-1:0] v;
      case (a)
         5'd1:    v = 8'sd90;
         5'd2:    v = 8'sd90;
         5'd3:    v = 8'sd90;
         5'd4:    v = 8'sd89;
         5'd5:    v = 8'sd88;
         5'd6:    v = 8'sd87;
         5'd7:    v = 8'sd85;
         5'd8:    v = 8'sd83;
         5'd9:    v = 8'sd82;
         5'd10:   v = 8'sd80;
         5'd11:   v = 8'sd78;
         5'd12:   v = 8'sd75;
         5'd13:   v = 8'sd73;
         5'd14:   v = 8'sd70;
         5'd15:   v = 8'sd67;
         5'd16:   v = 8'sd64;
         5'd17:   v = 8'sd61;
         5'd18:   v = 8'sd57;
         5'd19:   v = 8'sd54;
         5'd20:   v = 8'sd50;
         5'd21:   v = 8'sd46;
         5'd22:   v = 8'sd43;
         5'd23:   v = 8'sd38;
         5'd24:   v = 8'sd36;
         5'd25:   v = 8'sd31;
         5'd26:   v = 8'sd25;
         5'd27:   v = 8'sd22;
         5'd28:   v = 8'sd18;
         5'd29:   v = 8'sd13;
         5'd30:   v = 8'sd9;
         5'd31:   v = 8'sd4;
         default: v = 8'sd64;
      endcase
      return v;
   endfunction

   // C_N[r][c] for N = 4 << sz, via row scaling into the 32-point matrix and
   // quadrant folding of the phase m = (2c+1)*k mod 128.
   function automatic logic signed [COEF_W-1:0] f_coef(input logic [1:0] sz,
                                                       input logic [4:0] r,
                                                       input logic [4:0] c);
      logic [4:0]               k;
      logic [6:0]               m;
      logic signed [COEF_W-1:0] v;
      k = r << (2'd3 - sz);
      m = {1'b0, c, 1'b1} * {2'b00, k};
      if (k == 5'd0)
         v = 8'sd64;
      else if (m < 7'd32)
         v = f_tval(m[4:0]);
      else if (m < 7'd64)
         v = -f_tval(5'(7'd64 - m));
      else if (m < 7'd96)
         v = -f_tval(5'(m - 7'd64));
      else
         v = f_tval(5'(7'd0 - m));
      return v;
   endfunction

   logic [0:0]               r_state;
   logic [4:0]               r_beat;
   logic                     r_err;
   logic [1:0]               r_size_p0;
   logic [4:0]               r_idx_p0;
   logic                     r_tr_p0;

   logic [5:0]               w_req_n;
   logic [5:0]               w_nbeats;
   logic                     w_legal;
   logic                     w_last;
   logic                     w_consume;
   logic                     w_accept;
   logic [8*LANES-1:0]       w_coeff;

   assign w_req_n   = 6'(6'd4 << req_size);
   assign w_legal   = ({1'b0, req_idx} < w_req_n);
   assign w_nbeats  = 6'(6'd4 << r_size_p0) >> LANE_LG;
   assign w_last    = (r_state == S_STREAM) && ({1'b0, r_beat} == (w_nbeats - 6'd1));

   assign out_valid = (r_state == S_STREAM);
   assign w_consume = out_valid && out_ready;
   // A request may be taken while idle or on the handshake of the final beat,
   // which is what lets consecutive vectors stream without a bubble.
   assign req_ready = (r_state == S_IDLE) || (w_consume && w_last);
   assign w_accept  = req_valid && req_ready;

   assign out_beat  = r_beat;
   assign out_last  = w_last;
   assign out_coeff = w_coeff;
   assign req_err   = r_err;

   // Control: FSM, beat counter and the one-cycle illegal-request pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_beat  <= 5'd0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_accept && !w_legal;
         if (w_accept) begin
            r_beat  <= 5'd0;
            r_state <= w_legal ? S_STREAM : S_IDLE;
         end else if (w_consume) begin
            if (w_last) begin
               r_state <= S_IDLE;
               r_beat  <= 5'd0;
            end else begin
               r_beat  <= r_beat + 5'd1;
            end
         end
      end
   end

   // Stage p0: request fields captured on acceptance of a legal request.
   always_ff @(posedge clk) begin
      if (w_accept && w_legal) begin
         r_size_p0 <= req_size;
         r_idx_p0  <= req_idx;
         r_tr_p0   <= req_transpose;
      end
   end

   // Beat assembly from registered state only; zero while no beat is valid.
   always_comb begin
      logic [4:0] j;
      w_coeff = '0;
      j       = 5'd0;
      if (r_state == S_STREAM) begin
         for (int l = 0; l < LANES; l++) begin
            j = 5'((int'(r_beat) << LANE_LG) + l);
            if (r_tr_p0)
               w_coeff[l*COEF_W +: COEF_W] = f_coef(r_size_p0, j, r_idx_p0);
            else
               w_coeff[l*COEF_W +: COEF_W] = f_coef(r_size_p0, r_idx_p0, j);
         end
      end
   end

endmodule

// File: tb/tb_hevc_dct_coeff_gen.sv
// tb_hevc_dct_coeff_gen
// Directed and randomized checks of hevc_dct_coeff_gen (LANES=4) against a
// reference built from a full-period 128-entry cosine-like table.

module tb_hevc_dct_coeff_gen;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_size;
   logic [4:0]  req_idx;
   logic        req_transpose;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_coeff;
   logic [4:0]  out_beat;
   logic        out_last;
   logic        req_err;

   int n_cmp = 0;
   int n_bad = 0;
   int tab [0:127];
   int tt  [0:31] = '{64, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67,
                      64, 61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4};

   hevc_dct_coeff_gen #(.LANES(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_size      (req_size),
      .req_idx       (req_idx),
      .req_transpose (req_transpose),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_coeff     (out_coeff),
      .out_beat      (out_beat),
      .out_last      (out_last),
      .req_err       (req_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Period table: first quadrant from T, zero at 32, odd symmetry about 32,
   // and sign flip across half a period.
   task automatic build_tab();
      tab[0]  = 64;
      for (int m = 1; m < 32; m++) tab[m] = tt[m];
      tab[32] = 0;
      for (int m = 33; m < 64; m++) tab[m] = -tab[64-m];
      for (int m = 64; m < 128; m++) tab[m] = -tab[m-64];
   endtask

   function automatic int mref(input int sz, input int r, input int c);
      int n, k;
      n = 4 << sz;
      k = r * (32 / n);
      return tab[((2*c + 1) * k) % 128];
   endfunction

   function automatic logic [31:0] exp_beat(input int sz, input int idx, input int tr, input int b);
      logic [31:0] e;
      int v, j;
      e = '0;
      for (int l = 0; l < 4; l++) begin
         j = b*4 + l;
         v = tr ? mref(sz, j, idx) : mref(sz, idx, j);
         e[l*8 +: 8] = v[7:0];
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int sz, input int idx, input int tr);
      bit legal;
      legal         = (idx < (4 << sz));
      req_valid     = 1'b1;
      req_size      = 2'(sz);
      req_idx       = 5'(idx);
      req_transpose = 1'(tr);
      #1;
      chk("issue_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      if (legal) begin
         chk("first_valid", 32'(out_valid), 32'd1);
         chk("first_beat", 32'(out_beat), 32'd0);
      end else begin
         chk("illegal_err", 32'(req_err), 32'd1);
         chk("illegal_novalid", 32'(out_valid), 32'd0);
      end
   endtask

   // Consumes beats first..nstop-1; optionally offers a new request on the
   // last-beat handshake.
   task automatic stream(input int sz, input int idx, input int tr, input int first,
                         input int nstop, input bit bp, input bit nxt, input int nsz,
                         input int nidx, input int ntr, input bit nlegal);
      int nb;
      nb = (4 << sz) / 4;
      for (int b = first; b < nstop; b++) begin
         int  tries;
         bit  done;
         tries = 0;
         done  = 1'b0;
         while (!done) begin
            bit lastb;
            lastb     = (b == nb - 1);
            out_ready = (bp && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (lastb && nxt && out_ready) begin
               req_valid     = 1'b1;
               req_size      = 2'(nsz);
               req_idx       = 5'(nidx);
               req_transpose = 1'(ntr);
            end else begin
               req_valid = 1'b0;
            end
            #1;
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_num", 32'(out_beat), 32'(b));
            chk("beat_coeff", out_coeff, exp_beat(sz, idx, tr, b));
            chk("beat_last", 32'(out_last), 32'(lastb));
            chk("req_ready", 32'(req_ready), 32'(out_ready && lastb));
            done = out_ready;
            tries++;
            tick();
         end
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      if (nstop == nb) begin
         if (nxt && !nlegal) begin
            chk("b2b_illegal_err", 32'(req_err), 32'd1);
            chk("b2b_illegal_idle", 32'(out_valid), 32'd0);
            tick();
            chk("err_pulse_end", 32'(req_err), 32'd0);
         end else if (!nxt) begin
            chk("end_idle", 32'(out_valid), 32'd0);
            chk("end_noerr", 32'(req_err), 32'd0);
         end
      end
   endtask

   initial begin
      int csz, cidx, ctr, nsz, nidx, ntr;
      bit pend, nxt;
      build_tab();
      rst_n = 1'b0; req_valid = 1'b0; req_size = 2'd0; req_idx = 5'd0;
      req_transpose = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(req_err), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_beat", 32'(out_beat), 32'd0);
      chk("rst_coeff", out_coeff, 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      tick();

      // Size 8 row 1, then back-to-back size 4 column 1.
      issue(1, 1, 0);
      chk("s8r1_b0", out_coeff, 32'h12324B59);
      stream(1, 1, 0, 0, 1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      chk("s8r1_b1", out_coeff, 32'hA7B5CEEE);
      chk("s8r1_b1_last", 32'(out_last), 32'd1);
      stream(1, 1, 0, 1, 2, 1'b0, 1'b1, 0, 1, 1, 1'b1);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("s4c1_b0", out_coeff, 32'hADC02440);
      chk("s4c1_beat", 32'(out_beat), 32'd0);
      chk("s4c1_last", 32'(out_last), 32'd1);
      stream(0, 1, 1, 0, 1, 1'b0, 1'b0, 0, 0, 0, 1'b1);

      // Size 32 row 1 and row 16.
      issue(3, 1, 0);
      chk("s32r1_b0", out_coeff, 32'h55585A5A);
      stream(3, 1, 0, 0, 7, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      chk("s32r1_b7", out_coeff, 32'hA6A6A8AB);
      stream(3, 1, 0, 7, 8, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      issue(3, 16, 0);
      chk("s32r16_b0", out_coeff, 32'h40C0C040);
      stream(3, 16, 0, 0, 8, 1'b0, 1'b0, 0, 0, 0, 1'b1);

      // Backpressure on size 8 row 2, with a changed request bus meanwhile.
      issue(1, 2, 0);
      out_ready = 1'b0;
      req_size = 2'd3; req_idx = 5'd9; req_transpose = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_coeff", out_coeff, 32'hADDC2453);
         chk("bp_beat", 32'(out_beat), 32'd0);
         chk("bp_ready", 32'(req_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'd0);
      tick();
      stream(1, 2, 0, 1, 2, 1'b0, 1'b0, 0, 0, 0, 1'b1);

      // Illegal request from idle, then illegal request on a last beat.
      issue(0, 5, 0);
      tick();
      chk("illegal_pulse_end", 32'(req_err), 32'd0);
      chk("illegal_still_idle", 32'(out_valid), 32'd0);
      issue(1, 0, 1);
      stream(1, 0, 1, 0, 2, 1'b0, 1'b1, 0, 7, 0, 1'b0);

      // Reset in the middle of a size 32 row 3 vector.
      issue(3, 3, 0);
      stream(3, 3, 0, 0, 3, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_coeff", out_coeff, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_rst_novalid", 32'(out_valid), 32'd0);
         chk("post_rst_beat", 32'(out_beat), 32'd0);
      end
      issue(2, 7, 1);
      stream(2, 7, 1, 0, 4, 1'b0, 1'b0, 0, 0, 0, 1'b1);

      // Randomized vectors with random backpressure and random chaining.
      pend = 1'b0;
      csz = 0; cidx = 0; ctr = 0;
      for (int it = 0; it < 25; it++) begin
         if (!pend) begin
            csz  = $urandom_range(0, 3);
            cidx = $urandom_range(0, (4 << csz) - 1);
            ctr  = $urandom_range(0, 1);
            issue(csz, cidx, ctr);
         end
         nxt  = 1'($urandom_range(0, 1));
         nsz  = $urandom_range(0, 3);
         nidx = $urandom_range(0, (4 << nsz) - 1);
         ntr  = $urandom_range(0, 1);
         stream(csz, cidx, ctr, 0, (4 << csz) / 4, 1'b1, nxt, nsz, nidx, ntr, 1'b1);
         pend = nxt;
         if (nxt) begin
            csz = nsz; cidx = nidx; ctr = ntr;
         end
      end
      if (pend)
         stream(csz, cidx, ctr, 0, (4 << csz) / 4, 1'b1, 1'b0, 0, 0, 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
